universal_shift_register: RTL



---
 rtl/usr_pkg.sv | 17 +
 rtl/usr_next_state.sv | 29 ++
 rtl/universal_shift_register.sv | 91 +++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and burst FSM states.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_next_state.sv
// Combinational next-q mux for the manual modes; code 3'b111 is reserved and holds.
module usr_next_state
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             ser_in_lo_i,
    input  logic             ser_in_hi_i,
    input  logic [WIDTH-1:0] par_in_i,
    output logic [WIDTH-1:0] q_next_o
);

    always_comb begin
        q_next_o = q_i;
        case (mode_i)
            MODE_HOLD: q_next_o = q_i;
            MODE_SHL:  q_next_o = {q_i[WIDTH-2:0], ser_in_lo_i};
            MODE_SHR:  q_next_o = {ser_in_hi_i, q_i[WIDTH-1:1]};
            MODE_ROL:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ROR:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_LOAD: q_next_o = par_in_i;
            MODE_CLR:  q_next_o = '0;
            default:   q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Parametrised shift/rotate/load register with an autonomous LSB-first burst serialiser.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             ser_in_lo,
    input  logic             ser_in_hi,
    input  logic [WIDTH-1:0] par_in,
    input  logic             burst_start,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out_lo,
    output logic             ser_out_hi,
    output logic             burst_busy,
    output logic             burst_done
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    usr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_manual;

    usr_next_state #(
        .WIDTH(WIDTH)
    ) u_next_state (
        .mode_i      (mode),
        .q_i         (q_q),
        .ser_in_lo_i (ser_in_lo),
        .ser_in_hi_i (ser_in_hi),
        .par_in_i    (par_in),
        .q_next_o    (q_manual)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (burst_start) begin
                    q_d     = par_in;
                    cnt_d   = CntLast;
                    state_d = SHIFT;
                end else if (en) begin
                    q_d = q_manual;
                end
            end
            SHIFT: begin
                q_d = {1'b0, q_q[WIDTH-1:1]};
                // Exit on equality so the counter parks at zero and never wraps.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign par_out    = q_q;
    assign ser_out_lo = q_q[0];
    assign ser_out_hi = q_q[WIDTH-1];
    assign burst_busy = (state_q == SHIFT);
    assign burst_done = done_q;

endmodule
